// File: rtl/writeback_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_scoreboard_pkg
// Description : Shared constants and types for the write-back scoreboard.
//               XLEN/NREGS/RA_W/REG_ZERO mirror the register bank's view of
//               the integer register file, so both blocks stay in step.
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_scoreboard_pkg;

    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int RA_W      = $clog2(NREGS);
    // Must be a power of two and at least 2 (pointers wrap by overflow).
    localparam int LSU_DEPTH = 2;

    localparam logic [RA_W-1:0] REG_ZERO = '0;

    // One pending result: destination plus data, as stored in the LSU FIFO.
    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    localparam int WB_ENTRY_W = $bits(wb_entry_t);

    // Which source loads the write-port register this cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_LSU  = 2'd2
    } wb_sel_e;

    // x0 is hardwired to zero: results aimed at it never reach the bank.
    function automatic logic writes_bank(input logic [RA_W-1:0] r);
        return (r != REG_ZERO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : writeback_scoreboard_if
// Description : Bundles the decode query/issue port, the ALU and LSU result
//               ports, and the register-bank write port of the scoreboard.
//               slave  : the scoreboard itself
//               master : the surrounding pipeline / bank (or a testbench)
// Revision    : 1.0 - initial release
// ============================================================================
interface writeback_scoreboard_if;
    import writeback_scoreboard_pkg::*;

    // decode query / issue
    logic [RA_W-1:0]  chk_rs1;
    logic [RA_W-1:0]  chk_rs2;
    logic [RA_W-1:0]  chk_rd;
    logic             issue_valid;
    logic             issue_stall;
    // ALU result (cannot be back-pressured)
    logic             alu_valid;
    logic [RA_W-1:0]  alu_rd;
    logic [XLEN-1:0]  alu_data;
    // LSU result (buffered)
    logic             lsu_valid;
    logic             lsu_ready;
    logic [RA_W-1:0]  lsu_rd;
    logic [XLEN-1:0]  lsu_data;
    // register-bank write port
    logic [RA_W-1:0]  rd;
    logic             reg_write;
    logic [XLEN-1:0]  rd_value;
    // debug
    logic [NREGS-1:0] busy_mask;

    modport slave (
        input  chk_rs1, chk_rs2, chk_rd, issue_valid,
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output issue_stall, lsu_ready,
        output rd, reg_write, rd_value, busy_mask
    );

    modport master (
        output chk_rs1, chk_rs2, chk_rd, issue_valid,
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  issue_stall, lsu_ready,
        input  rd, reg_write, rd_value, busy_mask
    );

endinterface
`default_nettype wire

// File: rtl/writeback_scoreboard_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Small synchronous FIFO holding LSU results until the write
//               port is free. Wrap-around read/write pointers plus an
//               occupancy count. A push while full or a pop while empty is
//               ignored; push and pop together leave the count unchanged.
// Ports       : clk, rst (async, active-low)
//               push/din  - write an entry (dropped when full)
//               pop       - discard the head entry (ignored when empty)
//               head      - current head entry (valid when !empty)
//               full/empty- occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] din,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/writeback_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : writeback_scoreboard
// Description : Merges ALU and LSU results onto the register bank's single
//               write port and tracks which destination registers still
//               have a result in flight. ALU results always take the port;
//               LSU results wait in a small FIFO.
// Ports       : clk  - clock, all state on rising edge
//               rst  - asynchronous, active-low reset
//               bus  - scoreboard side of writeback_scoreboard_if:
//                      decode check/issue, ALU/LSU results, bank write port,
//                      busy_mask debug view
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_scoreboard
    import writeback_scoreboard_pkg::*;
(
    input wire logic              clk,
    input wire logic              rst,
    writeback_scoreboard_if.slave bus
);

    logic [NREGS-1:0]      busy_q, busy_d;
    logic [RA_W-1:0]       rd_q, rd_d;
    logic                  reg_write_q, reg_write_d;
    logic [XLEN-1:0]       rd_value_q, rd_value_d;

    logic                  issue_stall;
    logic                  issue_ok;
    wb_sel_e               sel;
    wb_entry_t             lsu_entry;
    wb_entry_t             fifo_head;
    logic [WB_ENTRY_W-1:0] fifo_head_bits;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;

    // ------------------------------------------------------------------
    // LSU result buffer
    // ------------------------------------------------------------------
    always_comb begin
        lsu_entry      = '0;
        lsu_entry.rd   = bus.lsu_rd;
        lsu_entry.data = bus.lsu_data;
    end

    assign fifo_push = bus.lsu_valid & ~fifo_full;
    assign fifo_head = wb_entry_t'(fifo_head_bits);

    wb_fifo #(
        .WIDTH (WB_ENTRY_W),
        .DEPTH (LSU_DEPTH)
    ) u_wb_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (lsu_entry),
        .pop   (fifo_pop),
        .head  (fifo_head_bits),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Hazard check. busy_q[0] is held at 0, so x0 never stalls.
    // ------------------------------------------------------------------
    assign issue_stall = busy_q[bus.chk_rs1] | busy_q[bus.chk_rs2] | busy_q[bus.chk_rd];
    assign issue_ok    = bus.issue_valid & ~issue_stall & writes_bank(bus.chk_rd);

    // ------------------------------------------------------------------
    // Scoreboard next state. The clear uses the registered write port, so
    // a register stays busy until the edge on which the bank captures the
    // value. The set is applied last so it wins a same-register collision.
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (reg_write_q) begin
            busy_d[rd_q] = 1'b0;
        end
        if (issue_ok) begin
            busy_d[bus.chk_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Write-port arbitration and output register load.
    // ------------------------------------------------------------------
    always_comb begin
        sel         = SEL_NONE;
        fifo_pop    = 1'b0;
        rd_d        = rd_q;
        rd_value_d  = rd_value_q;
        reg_write_d = 1'b0;
        if (bus.alu_valid) begin
            sel = SEL_ALU;
        end else if (!fifo_empty) begin
            sel = SEL_LSU;
        end
        case (sel)
            SEL_ALU: begin
                rd_d        = bus.alu_rd;
                rd_value_d  = bus.alu_data;
                reg_write_d = writes_bank(bus.alu_rd);
            end
            SEL_LSU: begin
                // An x0 entry is still consumed; it just never writes.
                fifo_pop    = 1'b1;
                rd_d        = fifo_head.rd;
                rd_value_d  = fifo_head.data;
                reg_write_d = writes_bank(fifo_head.rd);
            end
            default: begin
                reg_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q      <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            rd_value_q  <= '0;
        end else begin
            busy_q      <= busy_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            rd_value_q  <= rd_value_d;
        end
    end

    assign bus.issue_stall = issue_stall;
    assign bus.lsu_ready   = ~fifo_full;
    assign bus.rd          = rd_q;
    assign bus.reg_write   = reg_write_q;
    assign bus.rd_value    = rd_value_q;
    assign bus.busy_mask   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_scoreboard
// Description : Directed self-checking bench for writeback_scoreboard:
//               reset, RAW stall/release, x0 handling, ALU/LSU contention,
//               FIFO full back-pressure and asynchronous reset mid-operation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_scoreboard;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    writeback_scoreboard_if bus ();

    writeback_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b0;
        bus.chk_rs1     = '0;
        bus.chk_rs2     = '0;
        bus.chk_rd      = '0;
        bus.issue_valid = 1'b0;
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_data    = '0;
        bus.lsu_valid   = 1'b0;
        bus.lsu_rd      = '0;
        bus.lsu_data    = '0;

        // ---------------- reset ----------------
        #2;
        chk("rst_busy",      bus.busy_mask, 32'h0);
        chk("rst_reg_write", 32'(bus.reg_write), 32'h0);
        chk("rst_lsu_ready", 32'(bus.lsu_ready), 32'h1);
        chk("rst_rd",        32'(bus.rd), 32'h0);
        chk("rst_rd_value",  bus.rd_value, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) tick();
        chk("idle_busy",      bus.busy_mask, 32'h0);
        chk("idle_reg_write", 32'(bus.reg_write), 32'h0);
        chk("idle_lsu_ready", 32'(bus.lsu_ready), 32'h1);

        // ---------------- RAW on x5 ----------------
        bus.chk_rd      = 5'd5;
        bus.issue_valid = 1'b1;
        #1;
        chk("raw_issue_nostall", 32'(bus.issue_stall), 32'h0);
        tick();
        bus.issue_valid = 1'b0;
        bus.chk_rd      = 5'd0;
        bus.chk_rs1     = 5'd5;
        #1;
        chk("raw_busy_set", bus.busy_mask, 32'h20);
        chk("raw_stall",    32'(bus.issue_stall), 32'h1);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 32'hDEADBEEF;
        tick();
        bus.alu_valid = 1'b0;
        #1;
        chk("raw_wr_en",      32'(bus.reg_write), 32'h1);
        chk("raw_wr_rd",      32'(bus.rd), 32'h5);
        chk("raw_wr_val",     bus.rd_value, 32'hDEADBEEF);
        chk("raw_stall_hold", 32'(bus.issue_stall), 32'h1);
        tick();
        chk("raw_stall_clr", 32'(bus.issue_stall), 32'h0);
        chk("raw_busy_clr",  bus.busy_mask, 32'h0);
        chk("raw_wr_done",   32'(bus.reg_write), 32'h0);

        // ---------------- x0 ----------------
        bus.chk_rs1     = 5'd0;
        bus.chk_rd      = 5'd0;
        bus.issue_valid = 1'b1;
        tick();
        bus.issue_valid = 1'b0;
        chk("x0_busy", bus.busy_mask, 32'h0);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_data  = 32'h55;
        tick();
        bus.alu_valid = 1'b0;
        chk("x0_no_write", 32'(bus.reg_write), 32'h0);

        // ---------------- ALU/LSU contention ----------------
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_data  = 32'h11;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd4;
        bus.lsu_data  = 32'h22;
        tick();
        bus.alu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        chk("cont_n1_en",  32'(bus.reg_write), 32'h1);
        chk("cont_n1_rd",  32'(bus.rd), 32'h3);
        chk("cont_n1_val", bus.rd_value, 32'h11);
        tick();
        chk("cont_n2_en",  32'(bus.reg_write), 32'h1);
        chk("cont_n2_rd",  32'(bus.rd), 32'h4);
        chk("cont_n2_val", bus.rd_value, 32'h22);
        tick();
        chk("cont_idle", 32'(bus.reg_write), 32'h0);

        // ---------------- FIFO full ----------------
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd1;
        bus.alu_data  = 32'hA0;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd6;
        bus.lsu_data  = 32'h66;
        #1;
        chk("full_a0_ready", 32'(bus.lsu_ready), 32'h1);
        tick();
        bus.alu_data = 32'hA1;
        bus.lsu_rd   = 5'd7;
        bus.lsu_data = 32'h77;
        #1;
        chk("full_a1_ready", 32'(bus.lsu_ready), 32'h1);
        chk("full_a0_rd",    32'(bus.rd), 32'h1);
        chk("full_a0_val",   bus.rd_value, 32'hA0);
        tick();
        bus.alu_data = 32'hA2;
        bus.lsu_rd   = 5'd8;
        bus.lsu_data = 32'h88;
        #1;
        chk("full_a2_ready", 32'(bus.lsu_ready), 32'h0);
        tick();
        bus.alu_data = 32'hA3;
        #1;
        chk("full_a3_ready", 32'(bus.lsu_ready), 32'h0);
        tick();
        bus.alu_valid = 1'b0;
        #1;
        chk("full_b0_ready", 32'(bus.lsu_ready), 32'h0);
        chk("full_a3_val",   bus.rd_value, 32'hA3);
        tick();
        chk("full_x6_en",    32'(bus.reg_write), 32'h1);
        chk("full_x6_rd",    32'(bus.rd), 32'h6);
        chk("full_x6_val",   bus.rd_value, 32'h66);
        chk("full_b1_ready", 32'(bus.lsu_ready), 32'h1);
        tick();
        bus.lsu_valid = 1'b0;
        chk("full_x7_rd",  32'(bus.rd), 32'h7);
        chk("full_x7_val", bus.rd_value, 32'h77);
        tick();
        chk("full_x8_en",  32'(bus.reg_write), 32'h1);
        chk("full_x8_rd",  32'(bus.rd), 32'h8);
        chk("full_x8_val", bus.rd_value, 32'h88);
        tick();
        chk("full_drain_en",    32'(bus.reg_write), 32'h0);
        chk("full_drain_ready", 32'(bus.lsu_ready), 32'h1);

        // ---------------- reset mid-operation ----------------
        bus.chk_rd      = 5'd6;
        bus.issue_valid = 1'b1;
        tick();
        bus.chk_rd = 5'd7;
        tick();
        bus.issue_valid = 1'b0;
        bus.chk_rd      = 5'd0;
        chk("mid_busy", bus.busy_mask, 32'hC0);
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd2;
        bus.alu_data  = 32'h12;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd    = 5'd6;
        bus.lsu_data  = 32'h66;
        tick();
        bus.alu_rd   = 5'd9;
        bus.alu_data = 32'h99;
        bus.lsu_rd   = 5'd7;
        bus.lsu_data = 32'h77;
        tick();
        bus.alu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        chk("mid_pre_en",    32'(bus.reg_write), 32'h1);
        chk("mid_pre_rd",    32'(bus.rd), 32'h9);
        chk("mid_pre_ready", 32'(bus.lsu_ready), 32'h0);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_busy",  bus.busy_mask, 32'h0);
        chk("mid_rst_en",    32'(bus.reg_write), 32'h0);
        chk("mid_rst_rd",    32'(bus.rd), 32'h0);
        chk("mid_rst_val",   bus.rd_value, 32'h0);
        chk("mid_rst_ready", 32'(bus.lsu_ready), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_stale", 32'(bus.reg_write), 32'h0);
        end
        chk("mid_final_busy", bus.busy_mask, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
